// File: rtl/prog_fetch.sv
`default_nettype none
// ============================================================================
// Module   : prog_fetch
// Function : GPU program fetch unit. Serves longword reads from the local RAM
//            page or from the external bus, with abort handling.
// Revision : 1.0 - initial release
// ============================================================================
module prog_fetch #(
    parameter logic [11:0] LOCAL_PAGE = 12'hF03
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        progreq,
    input  logic [21:0] progaddr,
    input  logic        pabort,
    output logic        progack,
    output logic [31:0] gpu_data,
    output logic        lram_rd,
    output logic [9:0]  lram_addr,
    input  logic [31:0] lram_dout,
    output logic        mreq,
    output logic [21:0] maddr,
    input  logic        mack,
    input  logic        mdvalid,
    input  logic [31:0] mdata,
    output logic        pfbusy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LRD    = 3'd1,
        S_LDAT   = 3'd2,
        S_XREQ   = 3'd3,
        S_XWAIT  = 3'd4,
        S_XDRAIN = 3'd5
    } state_t;

    state_t      state_q;
    logic [21:0] addr_q;
    logic        progack_q;
    logic [31:0] gpu_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= 22'd0;
            progack_q  <= 1'b0;
            gpu_data_q <= 32'd0;
        end else begin
            progack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (progreq && !pabort) begin
                        addr_q  <= progaddr;
                        state_q <= (progaddr[21:10] == LOCAL_PAGE) ? S_LRD : S_XREQ;
                    end
                end
                S_LRD: begin
                    state_q <= pabort ? S_IDLE : S_LDAT;
                end
                S_LDAT: begin
                    state_q <= S_IDLE;
                    if (!pabort) begin
                        gpu_data_q <= lram_dout;
                        progack_q  <= 1'b1;
                    end
                end
                S_XREQ: begin
                    // An abort after the bus has accepted the request must still absorb its data beat.
                    if (mack)
                        state_q <= pabort ? S_XDRAIN : S_XWAIT;
                    else if (pabort)
                        state_q <= S_IDLE;
                end
                S_XWAIT: begin
                    if (mdvalid) begin
                        state_q <= S_IDLE;
                        if (!pabort) begin
                            gpu_data_q <= mdata;
                            progack_q  <= 1'b1;
                        end
                    end else if (pabort) begin
                        state_q <= S_XDRAIN;
                    end
                end
                S_XDRAIN: begin
                    if (mdvalid)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign progack   = progack_q;
    assign gpu_data  = gpu_data_q;
    assign lram_rd   = (state_q == S_LRD);
    assign lram_addr = addr_q[9:0];
    assign mreq      = (state_q == S_XREQ);
    assign maddr     = addr_q;
    assign pfbusy    = (state_q != S_IDLE);

endmodule
`default_nettype wire
